// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
//   Initiator side of the cv32e40p multiplier port. Multiply commands from the
//   EX-stage sequencer are buffered in a small FIFO. The head entry is
//   presented to the multiplier, and each result is captured, together with
//   its tag, into a one-entry response register.
//
//   Optional feature: define MUL_ISSUE_TIMEOUT_EN to build a watchdog that
//   sets err_timeout_o once a single operation has stalled TIMEOUT_CYC cycles.
//   Without the macro, no counter is built and err_timeout_o is tied to 0.
//
// Ports
//   clk, rst_n             clock (rising edge), synchronous active-low reset
//   cmd_*                  valid/ready command input (operator, operands, imm,
//                          signedness, tag)
//   mul_enable_o           multiplier enable_i
//   mul_ex_ready_o         multiplier ex_ready_i (low while a response is stuck)
//   mul_operator_o ..      operator/operand/imm/signedness taken from FIFO head
//   mul_result_i/ready_i   multiplier result_o / ready_o
//   rsp_*                  valid/ready response output (result + tag)
//   err_timeout_o          sticky watchdog error
module mul_issue_ctrl #(
    parameter int CMD_DEPTH   = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_operator_i,
    input  logic [31:0]      cmd_op_a_i,
    input  logic [31:0]      cmd_op_b_i,
    input  logic [31:0]      cmd_op_c_i,
    input  logic [4:0]       cmd_imm_i,
    input  logic [1:0]       cmd_short_signed_i,
    input  logic [TAG_W-1:0] cmd_tag_i,
    output logic             mul_enable_o,
    output logic             mul_ex_ready_o,
    output logic [2:0]       mul_operator_o,
    output logic [31:0]      mul_op_a_o,
    output logic [31:0]      mul_op_b_o,
    output logic [31:0]      mul_op_c_o,
    output logic [4:0]       mul_imm_o,
    output logic [1:0]       mul_short_signed_o,
    input  logic [31:0]      mul_result_i,
    input  logic             mul_ready_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             err_timeout_o
);

    localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Elaboration-time parameter sanity checks.
    generate
        if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("CMD_DEPTH must be a power of two and at least 2");
        end
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    typedef struct packed {
        logic [2:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      c;
        logic [4:0]       imm;
        logic [1:0]       ss;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    cmd_t             fifo_q [CMD_DEPTH];
    cmd_t             fifo_d [CMD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    cmd_t             cmd_in;
    cmd_t             head;
    logic             push;
    logic             done;

    assign cmd_in = '{op: cmd_operator_i, a: cmd_op_a_i, b: cmd_op_b_i, c: cmd_op_c_i,
                      imm: cmd_imm_i, ss: cmd_short_signed_i, tag: cmd_tag_i};
    assign head   = fifo_q[rd_ptr_q];

    // Ready comes only from the registered count, so a push into a full FIFO is
    // refused even if the head is popped in that same cycle.
    assign cmd_ready_o    = (count_q != CNT_W'(CMD_DEPTH));
    assign push           = cmd_valid_i && cmd_ready_o;
    // The multiplier may only finish when the response slot is free or being
    // drained this cycle, so a held result is never overwritten.
    assign mul_ex_ready_o = !rsp_valid_q || rsp_ready_i;
    assign done           = (state_q == S_BUSY) && mul_ready_i && mul_ex_ready_o;

    assign mul_enable_o       = (state_q == S_BUSY);
    assign mul_operator_o     = head.op;
    assign mul_op_a_o         = head.a;
    assign mul_op_b_o         = head.b;
    assign mul_op_c_o         = head.c;
    assign mul_imm_o          = head.imm;
    assign mul_short_signed_o = head.ss;

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_tag_o    = rsp_tag_q;

    // FIFO, pointers, response register
    always_comb begin
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;

        if (push) begin
            fifo_d[wr_ptr_q] = cmd_in;
            wr_ptr_d         = wr_ptr_q + 1'b1;   // wraps modulo CMD_DEPTH
        end
        if (done) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(done);

        // A completion takes priority over a drain: the slot is reloaded with
        // no gap cycle.
        if (done) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = mul_result_i;
            rsp_tag_d    = head.tag;
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Issue FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (count_d != '0) state_d = S_BUSY;
            S_BUSY: if (done && (count_d == '0)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    // Storage is cleared on reset so the head-driven mul_* operands read 0.
    generate
        for (genvar gi = 0; gi < CMD_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    fifo_q[gi] <= '0;
                end else begin
                    fifo_q[gi] <= fifo_d[gi];
                end
            end
        end
    endgenerate

`ifdef MUL_ISSUE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_q, err_d;

    // Counts stalled BUSY cycles of the current operation. It saturates at the
    // limit so the error condition is reached exactly once per long stall.
    always_comb begin
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        if (done) begin
            to_cnt_d = '0;
        end else if ((state_q == S_BUSY) && (to_cnt_q != TO_W'(TIMEOUT_CYC))) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (to_cnt_d == TO_W'(TIMEOUT_CYC)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_timeout_o = err_q;
`else
    assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_operator_i;
    logic [31:0] cmd_op_a_i, cmd_op_b_i, cmd_op_c_i;
    logic [4:0]  cmd_imm_i;
    logic [1:0]  cmd_short_signed_i;
    logic [3:0]  cmd_tag_i;
    logic        mul_enable_o, mul_ex_ready_o;
    logic [2:0]  mul_operator_o;
    logic [31:0] mul_op_a_o, mul_op_b_o, mul_op_c_o;
    logic [4:0]  mul_imm_o;
    logic [1:0]  mul_short_signed_o;
    logic [31:0] mul_result_i;
    logic        mul_ready_i;
    logic        rsp_valid_o, rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic [3:0]  rsp_tag_o;
    logic        err_timeout_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 0;   // cycles ready_o stays low per operation
    int st       = 0;   // stalled cycles of the current operation
    logic [35:0] sb[$]; // expected {result, tag}
    int pop_cyc[$];

    always #5 clk = ~clk;

    mul_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_operator_i(cmd_operator_i), .cmd_op_a_i(cmd_op_a_i),
        .cmd_op_b_i(cmd_op_b_i), .cmd_op_c_i(cmd_op_c_i),
        .cmd_imm_i(cmd_imm_i), .cmd_short_signed_i(cmd_short_signed_i),
        .cmd_tag_i(cmd_tag_i),
        .mul_enable_o(mul_enable_o), .mul_ex_ready_o(mul_ex_ready_o),
        .mul_operator_o(mul_operator_o), .mul_op_a_o(mul_op_a_o),
        .mul_op_b_o(mul_op_b_o), .mul_op_c_o(mul_op_c_o),
        .mul_imm_o(mul_imm_o), .mul_short_signed_o(mul_short_signed_o),
        .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o),
        .err_timeout_o(err_timeout_o)
    );

    // Behavioural multiplier: MAC32 (0) = a*b+c, MUL_H (6) = signed high word.
    function automatic logic [31:0] mul_model(input logic [2:0] op,
                                              input logic [31:0] a, b, c);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        case (op)
            3'd0:    return a * b + c;
            3'd6:    return p[63:32];
            default: return a * b;
        endcase
    endfunction

    assign mul_result_i = mul_model(mul_operator_o, mul_op_a_o, mul_op_b_o, mul_op_c_o);
    assign mul_ready_i  = mul_enable_o && (st >= lat);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mul_enable_o || (mul_ready_i && mul_ex_ready_o)) st <= 0;
        else st <= st + 1;
    end

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && rsp_valid_o && rsp_ready_i) begin
            pop_cyc.push_back(cyc);
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got result=%h tag=%h, required no response",
                         rsp_result_o, rsp_tag_o);
            end else begin
                logic [35:0] e;
                e = sb.pop_front();
                if ({rsp_result_o, rsp_tag_o} !== e) begin
                    n_fail++;
                    $display("FAIL rsp_data: got result=%h tag=%h, required result=%h tag=%h",
                             rsp_result_o, rsp_tag_o, e[35:4], e[3:0]);
                end else begin
                    $display("rsp result=%h tag=%h ok (cycle %0d)", rsp_result_o, rsp_tag_o, cyc);
                end
            end
        end
    end

    task automatic push_cmd(input logic [2:0] op, input logic [31:0] a, b, c,
                            input logic [3:0] tag, input logic [31:0] exp);
        bit acc = 0;
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_operator_i = op;
        cmd_op_a_i = a; cmd_op_b_i = b; cmd_op_c_i = c;
        cmd_imm_i = 5'd0; cmd_short_signed_i = 2'b11; cmd_tag_i = tag;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                sb.push_back({exp, tag});
                acc = 1;
                break;
            end
        end
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: got cmd_ready_o=0 for 300 cycles, required 1 (tag %h)", tag);
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        $display("cmd op=%0d a=%h b=%h c=%h tag=%h pushed", op, a, b, c, tag);
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_operator_i = '0;
        cmd_op_a_i = '0; cmd_op_b_i = '0; cmd_op_c_i = '0; cmd_imm_i = '0;
        cmd_short_signed_i = '0; cmd_tag_i = '0; rsp_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready_o, mul_enable_o, rsp_valid_o, mul_ex_ready_o, err_timeout_o} !== 5'b10010) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/en/vld/exrdy/err=%b, required 10010",
                     {cmd_ready_o, mul_enable_o, rsp_valid_o, mul_ex_ready_o, err_timeout_o});
        end
        n_checks++;
        if ({rsp_result_o, rsp_tag_o, mul_op_a_o, mul_op_b_o, mul_op_c_o, mul_operator_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got result=%h tag=%h a=%h b=%h c=%h, required all 0",
                     rsp_result_o, rsp_tag_o, mul_op_a_o, mul_op_b_o, mul_op_c_o);
        end
        $display("reset checked");
    endtask

    task automatic test_single();
        lat = 0;
        push_cmd(3'd0, 32'd3, 32'd5, 32'd0, 4'd1, 32'd15);
        @(negedge clk);
        n_checks++;
        if (mul_enable_o !== 1'b1 || mul_op_a_o !== 32'd3 || mul_op_b_o !== 32'd5) begin
            n_fail++;
            $display("FAIL single_issue: got en=%b a=%h b=%h, required en=1 a=3 b=5",
                     mul_enable_o, mul_op_a_o, mul_op_b_o);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd15 || rsp_tag_o !== 4'd1) begin
            n_fail++;
            $display("FAIL single_rsp: got vld=%b result=%h tag=%h, required vld=1 result=f tag=1",
                     rsp_valid_o, rsp_result_o, rsp_tag_o);
        end
        wait_drain();
    endtask

    task automatic test_mul_h();
        int en_cycles = 0;
        lat = 4;
        push_cmd(3'd6, 32'h8000_0000, 32'd2, 32'd0, 4'd2, 32'hFFFF_FFFF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid_o) break;
            if (mul_enable_o) en_cycles++;
            n_checks++;
            if (mul_enable_o !== 1'b1 || mul_op_a_o !== 32'h8000_0000 || mul_op_b_o !== 32'd2
                || mul_operator_o !== 3'd6) begin
                n_fail++;
                $display("FAIL mulh_hold: got en=%b op=%0d a=%h b=%h, required en=1 op=6 a=80000000 b=2",
                         mul_enable_o, mul_operator_o, mul_op_a_o, mul_op_b_o);
            end
        end
        n_checks++;
        if (en_cycles != 5 || rsp_result_o !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL mulh_rsp: got %0d enable cycles result=%h, required 5 cycles result=ffffffff",
                     en_cycles, rsp_result_o);
        end
        wait_drain();
        lat = 0;
    endtask

    task automatic test_back_to_back();
        int pre;
        lat = 1000;
        for (int t = 0; t < 4; t++)
            push_cmd(3'd0, 32'(t + 1), 32'(t + 2), 32'(t), 4'(t), 32'((t + 1) * (t + 2) + t));
        @(negedge clk);
        n_checks++;
        if (cmd_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_full: got cmd_ready_o=%b, required 0", cmd_ready_o);
        end
        pre = pop_cyc.size();
        lat = 0;
        push_cmd(3'd0, 32'd5, 32'd6, 32'd4, 4'd4, 32'd34);
        wait_drain();
        n_checks++;
        if (pop_cyc.size() - pre != 5 || pop_cyc[pre + 4] - pop_cyc[pre] != 4) begin
            n_fail++;
            $display("FAIL burst_bubble: got %0d responses over %0d cycles, required 5 over 4",
                     pop_cyc.size() - pre, pop_cyc[pop_cyc.size() - 1] - pop_cyc[pre]);
        end
    endtask

    task automatic test_backpressure();
        lat = 0;
        rsp_ready_i = 1'b0;
        push_cmd(3'd0, 32'd7, 32'd9, 32'd1, 4'd5, 32'd64);
        push_cmd(3'd0, 32'd2, 32'd3, 32'd4, 4'd6, 32'd10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (mul_ex_ready_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd64
                || rsp_tag_o !== 4'd5 || mul_enable_o !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold: got exrdy=%b vld=%b result=%h tag=%h en=%b, required 0 1 40 5 1",
                         mul_ex_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o, mul_enable_o);
            end
        end
        @(posedge clk); #1;
        rsp_ready_i = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_busy();
        lat = 1000;
        for (int t = 0; t < 3; t++)
            push_cmd(3'd0, 32'd9, 32'(t), 32'd0, 4'(t + 10), 32'(9 * t));
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        n_checks++;
        if (mul_enable_o !== 1'b0 || cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0
            || mul_op_a_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_busy: got en=%b rdy=%b vld=%b a=%h, required 0 1 0 0",
                     mul_enable_o, cmd_ready_o, rsp_valid_o, mul_op_a_o);
        end
        lat = 0;
        push_cmd(3'd0, 32'd4, 32'd4, 32'd2, 4'd9, 32'd18);
        wait_drain();
    endtask

    task automatic test_timeout();
        logic exp_err;
`ifdef MUL_ISSUE_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        lat = 70;
        push_cmd(3'd0, 32'd6, 32'd7, 32'd0, 4'd3, 32'd42);
        wait_drain();
        @(negedge clk);
        n_checks++;
        if (err_timeout_o !== exp_err) begin
            n_fail++;
            $display("FAIL timeout_err: got err_timeout_o=%b, required %b", err_timeout_o, exp_err);
        end
        lat = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_mul_h();
        test_back_to_back();
        test_backpressure();
        test_reset_busy();
        test_timeout();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

endmodule
